// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory controller port between a buffered PCI host
//            write path and a handshaked user read/write request stream.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int FIFO_DEPTH  = 4,
    parameter int PCI_RUN_MAX = 8,
    parameter int RD_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pci_wr_en,
    input  logic [20:0] pci_req_addr,
    input  logic [31:0] pci_input_data,
    input  logic        usr_req,
    input  logic        usr_rd_wr,
    input  logic [20:0] usr_addr,
    input  logic [31:0] usr_wdata,
    output logic        usr_ack,
    output logic        usr_rd_valid,
    output logic [31:0] usr_rd_data,
    output logic        mem_rd_req,
    output logic        mem_wr_en,
    output logic [20:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rd_ready,
    input  logic [31:0] mem_rd_data,
    output logic        pci_fifo_full,
    output logic        pci_overflow,
    output logic        rd_timeout
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_RUN_W = $clog2(PCI_RUN_MAX + 1);
    localparam int c_TO_W  = $clog2(RD_TIMEOUT + 1);

    localparam logic [c_CNT_W-1:0] c_FIFO_FULL_CNT = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX       = c_RUN_W'(PCI_RUN_MAX);
    localparam logic [c_TO_W-1:0]  c_TO_LAST       = c_TO_W'(RD_TIMEOUT - 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_PCI_WR   = 3'd1;
    localparam logic [2:0] c_ST_USR_WR   = 3'd2;
    localparam logic [2:0] c_ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] c_ST_RD_WAIT  = 3'd4;

    // PCI write FIFO storage and bookkeeping
    logic [20:0]        r_fifo_addr [FIFO_DEPTH];
    logic [31:0]        r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_fifo_cnt;
    logic               r_overflow;

    // Arbiter state and registered outputs
    logic [2:0]         r_state;
    logic [c_RUN_W-1:0] r_pci_run;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic               r_usr_ack;
    logic               r_usr_rd_valid;
    logic [31:0]        r_usr_rd_data;
    logic               r_mem_rd_req;
    logic               r_mem_wr_en;
    logic [20:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_rd_timeout;

    logic w_fifo_empty;
    logic w_fifo_full;
    logic w_grant_st;
    logic w_pci_grant;
    logic w_usr_grant;
    logic w_push;
    logic w_pop;

    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_fifo_full  = (r_fifo_cnt == c_FIFO_FULL_CNT);
    assign w_grant_st   = (r_state == c_ST_IDLE) || (r_state == c_ST_PCI_WR) ||
                          (r_state == c_ST_USR_WR);
    // PCI wins unless a user request has already waited out a full PCI run.
    assign w_pci_grant  = w_grant_st && !w_fifo_empty &&
                          (!usr_req || (r_pci_run < c_RUN_MAX));
    // r_usr_ack doubles as the ack-pending flag: the request just acknowledged
    // is still visible on usr_req for one cycle and must not be served again.
    assign w_usr_grant  = w_grant_st && !w_pci_grant && usr_req && !r_usr_ack;
    assign w_pop        = w_pci_grant;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push       = pci_wr_en && (!w_fifo_full || w_pop);

    // FIFO entry write; storage needs no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= pci_req_addr;
            r_fifo_data[r_wr_ptr] <= pci_input_data;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            if (pci_wr_en && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Arbiter FSM; port outputs are registered alongside the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_pci_run      <= '0;
            r_to_cnt       <= '0;
            r_usr_ack      <= 1'b0;
            r_usr_rd_valid <= 1'b0;
            r_usr_rd_data  <= '0;
            r_mem_rd_req   <= 1'b0;
            r_mem_wr_en    <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_rd_timeout   <= 1'b0;
        end else begin
            r_usr_ack      <= 1'b0;
            r_usr_rd_valid <= 1'b0;
            r_mem_rd_req   <= 1'b0;
            r_mem_wr_en    <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;

            if (!usr_req || w_usr_grant) begin
                r_pci_run <= '0;
            end else if (w_pci_grant && (r_pci_run != c_RUN_MAX)) begin
                r_pci_run <= r_pci_run + 1'b1;
            end

            case (r_state)
                c_ST_IDLE, c_ST_PCI_WR, c_ST_USR_WR: begin
                    if (w_pci_grant) begin
                        r_state     <= c_ST_PCI_WR;
                        r_mem_wr_en <= 1'b1;
                        r_mem_addr  <= r_fifo_addr[r_rd_ptr];
                        r_mem_wdata <= r_fifo_data[r_rd_ptr];
                    end else if (w_usr_grant && usr_rd_wr) begin
                        r_state     <= c_ST_USR_WR;
                        r_mem_wr_en <= 1'b1;
                        r_mem_addr  <= usr_addr;
                        r_mem_wdata <= usr_wdata;
                        r_usr_ack   <= 1'b1;
                    end else if (w_usr_grant) begin
                        r_state      <= c_ST_RD_ISSUE;
                        r_mem_rd_req <= 1'b1;
                        r_mem_addr   <= usr_addr;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_RD_ISSUE: begin
                    r_state    <= c_ST_RD_WAIT;
                    r_to_cnt   <= '0;
                    r_mem_addr <= usr_addr;
                end
                c_ST_RD_WAIT: begin
                    if (mem_rd_ready) begin
                        r_state        <= c_ST_IDLE;
                        r_usr_rd_data  <= mem_rd_data;
                        r_usr_ack      <= 1'b1;
                        r_usr_rd_valid <= 1'b1;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_state        <= c_ST_IDLE;
                        r_rd_timeout   <= 1'b1;
                        r_usr_rd_data  <= '0;
                        r_usr_ack      <= 1'b1;
                        r_usr_rd_valid <= 1'b1;
                    end else begin
                        r_to_cnt   <= r_to_cnt + 1'b1;
                        r_mem_addr <= usr_addr;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign usr_ack       = r_usr_ack;
    assign usr_rd_valid  = r_usr_rd_valid;
    assign usr_rd_data   = r_usr_rd_data;
    assign mem_rd_req    = r_mem_rd_req;
    assign mem_wr_en     = r_mem_wr_en;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign pci_fifo_full = w_fifo_full;
    assign pci_overflow  = r_overflow;
    assign rd_timeout    = r_rd_timeout;

endmodule
`default_nettype wire
